bp_fpga_host_mmio_packer: RTL and testbench

Generalized MMIO host engine for BlackParrot on FPGA. It sits between the BP I/O-out AXI-to-FIFO adapter (FSM side) and the host CSR FIFOs. Each BP I/O request is serialized into a header word, address words and data words of parametrized width into a host-readable request FIFO. Read responses are reassembled from one or more host words. Writes are either posted or host-acknowledged, selected by parameter.

---
 rtl/bp_fpga_host_mmio_packer_if.sv | 39 +++
 rtl/bp_fpga_host_mmio_packer.sv | 165 ++++++++++++++++
 tb/tb_bp_fpga_host_mmio_packer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fpga_host_mmio_packer_if.sv
// Request/response, host FIFO and status signals of the MMIO packer, named from the engine's side.
interface bp_fpga_host_mmio_packer_if #(
  parameter int addr_width_p      = 64,
  parameter int data_width_p      = 64,
  parameter int fifo_data_width_p = 32
);
  logic                         req_v_i;
  logic [addr_width_p-1:0]      req_addr_i;
  logic [data_width_p-1:0]      req_data_i;
  logic                         req_w_i;
  logic [2:0]                   req_size_i;
  logic                         req_yumi_o;
  logic                         resp_v_o;
  logic                         resp_w_o;
  logic [data_width_p-1:0]      resp_data_o;
  logic                         resp_ready_and_i;
  logic                         mmio_v_o;
  logic [fifo_data_width_p-1:0] mmio_data_o;
  logic                         mmio_yumi_i;
  logic [fifo_data_width_p-1:0] mmio_count_o;
  logic                         mmio_v_i;
  logic [fifo_data_width_p-1:0] mmio_data_i;
  logic                         mmio_ready_and_o;
  logic                         error_o;

  modport slave (
    input  req_v_i, req_addr_i, req_data_i, req_w_i, req_size_i, resp_ready_and_i,
           mmio_yumi_i, mmio_v_i, mmio_data_i,
    output req_yumi_o, resp_v_o, resp_w_o, resp_data_o, mmio_v_o, mmio_data_o,
           mmio_count_o, mmio_ready_and_o, error_o
  );

  modport master (
    output req_v_i, req_addr_i, req_data_i, req_w_i, req_size_i, resp_ready_and_i,
           mmio_yumi_i, mmio_v_i, mmio_data_i,
    input  req_yumi_o, resp_v_o, resp_w_o, resp_data_o, mmio_v_o, mmio_data_o,
           mmio_count_o, mmio_ready_and_o, error_o
  );
endinterface

// File: rtl/bp_fpga_host_mmio_packer.sv
// Serializes BP I/O requests into host FIFO words (header, address, data) and
// rebuilds read/ack responses from host words.
module bp_fpga_host_mmio_packer #(
  parameter int addr_width_p      = 64,
  parameter int data_width_p      = 64,
  parameter int fifo_data_width_p = 32,
  parameter int mmio_els_p        = 64,
  parameter int write_ack_p       = 0
) (
  input logic                     s_axi_aclk,
  input logic                     s_axi_aresetn,
  bp_fpga_host_mmio_packer_if.slave io
);
  localparam int F    = fifo_data_width_p;
  localparam int B    = $clog2(data_width_p/8);
  localparam int A    = addr_width_p/F;
  localparam int DMAX = data_width_p/F;
  localparam int CW   = $clog2((A > DMAX) ? A : DMAX) + 1;
  localparam int PW   = (mmio_els_p > 1) ? $clog2(mmio_els_p) : 1;
  localparam int NW   = $clog2(mmio_els_p+1);

  typedef enum logic [2:0] {e_header, e_addr, e_data, e_read, e_wack, e_resp} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              size_q;
  logic                    w_q, err_q, rdy_q;
  logic [data_width_p-1:0] rdata_q;

  logic [F-1:0]  rq_mem [mmio_els_p];
  logic [PW-1:0] rq_wptr_q, rq_rptr_q;
  logic [NW-1:0] rq_cnt_q;
  logic [F-1:0]  rs_mem [mmio_els_p];
  logic [PW-1:0] rs_wptr_q, rs_rptr_q;
  logic [NW-1:0] rs_cnt_q;

  logic                    emit, enq, rq_deq, rq_space, rs_push, pop;
  logic [F-1:0]            rq_word, hdr, rs_head;
  logic [2:0]              size_eff;
  logic [CW-1:0]           dw;
  logic [data_width_p-1:0] mask, payload, repl;

  function automatic logic [CW-1:0] data_words(input logic [2:0] s);
    int bits;
    bits = 8 << s;
    return (bits <= F) ? CW'(1) : CW'(bits / F);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(mmio_els_p-1)) ? '0 : p + PW'(1);
  endfunction

  assign size_eff = (io.req_size_i > 3'(B)) ? 3'(B) : io.req_size_i;
  assign dw       = data_words(size_q);
  // A full request FIFO still accepts a word in the cycle the host dequeues one.
  assign rq_deq   = io.mmio_yumi_i && (rq_cnt_q != '0);
  assign rq_space = (rq_cnt_q != NW'(mmio_els_p)) || io.mmio_yumi_i;
  assign rs_push  = io.mmio_v_i && io.mmio_ready_and_o;
  assign rs_head  = rs_mem[rs_rptr_q];
  assign pop      = ((state_q == e_read) || (state_q == e_wack)) && (rs_cnt_q != '0);

  assign io.mmio_v_o         = (rq_cnt_q != '0);
  assign io.mmio_data_o      = rq_mem[rq_rptr_q];
  assign io.mmio_count_o     = F'(rq_cnt_q);
  assign io.mmio_ready_and_o = rdy_q && (rs_cnt_q != NW'(mmio_els_p));
  assign io.error_o          = err_q;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= e_header;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      e_header: if (enq) begin state_d = e_addr; cnt_d = '0; end
      e_addr: if (enq) begin
        if (cnt_q == CW'(A-1)) begin
          cnt_d   = '0;
          state_d = w_q ? e_data : e_read;
        end else cnt_d = cnt_q + CW'(1);
      end
      e_data: if (enq) begin
        if (cnt_q == dw - CW'(1)) begin
          cnt_d   = '0;
          state_d = (write_ack_p != 0) ? e_wack : e_resp;
        end else cnt_d = cnt_q + CW'(1);
      end
      e_read: if (pop) begin
        if (cnt_q == dw - CW'(1)) begin
          cnt_d   = '0;
          state_d = e_resp;
        end else cnt_d = cnt_q + CW'(1);
      end
      e_wack: if (pop) state_d = e_resp;
      e_resp: if (io.resp_ready_and_i) state_d = e_header;
      default: state_d = e_header;
    endcase
  end

  always_comb begin
    hdr             = '0;
    hdr[F-1]        = io.req_w_i;
    hdr[F-2 -: 3]   = size_eff;
    mask            = ~({data_width_p{1'b1}} << (32'd8 << size_q));
    payload         = (io.req_data_i >> {io.req_addr_i[B-1:0], 3'b000}) & mask;
    emit            = 1'b0;
    rq_word         = hdr;
    unique case (state_q)
      e_header: emit = io.req_v_i;
      e_addr:   begin emit = 1'b1; rq_word = io.req_addr_i[int'(cnt_q)*F +: F]; end
      e_data:   begin emit = 1'b1; rq_word = payload[int'(cnt_q)*F +: F]; end
      default:  emit = 1'b0;
    endcase
    enq             = emit && rq_space;
    io.req_yumi_o   = enq && (((state_q == e_addr) && (cnt_q == CW'(A-1)) && !w_q)
                           || ((state_q == e_data) && (cnt_q == dw - CW'(1))));
    // Read data: the low 8<<size bits repeat across the whole bus.
    for (int i = 0; i < data_width_p/8; i++)
      repl[i*8 +: 8] = rdata_q[(i & ((1 << size_q) - 1))*8 +: 8];
    io.resp_v_o     = (state_q == e_resp);
    io.resp_w_o     = w_q;
    io.resp_data_o  = w_q ? '0 : repl;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rq_wptr_q <= '0;
      rq_rptr_q <= '0;
      rq_cnt_q  <= '0;
      rs_wptr_q <= '0;
      rs_rptr_q <= '0;
      rs_cnt_q  <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (enq)    rq_wptr_q <= next_ptr(rq_wptr_q);
      if (rq_deq) rq_rptr_q <= next_ptr(rq_rptr_q);
      if (enq && !rq_deq)      rq_cnt_q <= rq_cnt_q + NW'(1);
      else if (!enq && rq_deq) rq_cnt_q <= rq_cnt_q - NW'(1);
      if (rs_push) rs_wptr_q <= next_ptr(rs_wptr_q);
      if (pop)     rs_rptr_q <= next_ptr(rs_rptr_q);
      if (rs_push && !pop)      rs_cnt_q <= rs_cnt_q + NW'(1);
      else if (!rs_push && pop) rs_cnt_q <= rs_cnt_q - NW'(1);
      if (enq && (state_q == e_header) && (io.req_size_i > 3'(B))) err_q <= 1'b1;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (enq)     rq_mem[rq_wptr_q] <= rq_word;
    if (rs_push) rs_mem[rs_wptr_q] <= io.mmio_data_i;
    if (enq && (state_q == e_header)) begin
      size_q <= size_eff;
      w_q    <= io.req_w_i;
    end
    if (pop && (state_q == e_read)) rdata_q[int'(cnt_q)*F +: F] <= rs_head;
  end
endmodule

// File: tb/tb_bp_fpga_host_mmio_packer.sv
// Directed and randomized bench for the MMIO packer: a posted-write DUT with a
// 4-deep FIFO and an acknowledged-write DUT, checked against a byte-level model.
module tb_bp_fpga_host_mmio_packer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic        req_v = 1'b0, req_w = 1'b0, resp_rdy = 1'b0, m_yumi = 1'b0, m_vi = 1'b0;
  logic [63:0] req_addr = '0, req_data = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] m_di = '0;
  int          checks = 0, failures = 0, yumi_cnt = 0;

  always #5 clk = ~clk;

  bp_fpga_host_mmio_packer_if #(.addr_width_p(64), .data_width_p(64), .fifo_data_width_p(32)) ifa ();
  bp_fpga_host_mmio_packer_if #(.addr_width_p(64), .data_width_p(64), .fifo_data_width_p(32)) ifb ();

  bp_fpga_host_mmio_packer #(.addr_width_p(64), .data_width_p(64), .fifo_data_width_p(32),
    .mmio_els_p(4), .write_ack_p(0)) dut_a (.s_axi_aclk(clk), .s_axi_aresetn(rstn), .io(ifa.slave));
  bp_fpga_host_mmio_packer #(.addr_width_p(64), .data_width_p(64), .fifo_data_width_p(32),
    .mmio_els_p(8), .write_ack_p(1)) dut_b (.s_axi_aclk(clk), .s_axi_aresetn(rstn), .io(ifb.slave));

  assign ifa.req_v_i = req_v & ~sel;          assign ifb.req_v_i = req_v & sel;
  assign ifa.req_addr_i = req_addr;           assign ifb.req_addr_i = req_addr;
  assign ifa.req_data_i = req_data;           assign ifb.req_data_i = req_data;
  assign ifa.req_w_i = req_w;                 assign ifb.req_w_i = req_w;
  assign ifa.req_size_i = req_size;           assign ifb.req_size_i = req_size;
  assign ifa.resp_ready_and_i = resp_rdy & ~sel; assign ifb.resp_ready_and_i = resp_rdy & sel;
  assign ifa.mmio_yumi_i = m_yumi & ~sel;     assign ifb.mmio_yumi_i = m_yumi & sel;
  assign ifa.mmio_v_i = m_vi & ~sel;          assign ifb.mmio_v_i = m_vi & sel;
  assign ifa.mmio_data_i = m_di;              assign ifb.mmio_data_i = m_di;

  wire        o_yumi   = sel ? ifb.req_yumi_o       : ifa.req_yumi_o;
  wire        o_rv     = sel ? ifb.resp_v_o         : ifa.resp_v_o;
  wire        o_rw     = sel ? ifb.resp_w_o         : ifa.resp_w_o;
  wire [63:0] o_rdata  = sel ? ifb.resp_data_o      : ifa.resp_data_o;
  wire        o_mv     = sel ? ifb.mmio_v_o         : ifa.mmio_v_o;
  wire [31:0] o_mdata  = sel ? ifb.mmio_data_o      : ifa.mmio_data_o;
  wire [31:0] o_mcount = sel ? ifb.mmio_count_o     : ifa.mmio_count_o;
  wire        o_mrdy   = sel ? ifb.mmio_ready_and_o : ifa.mmio_ready_and_o;
  wire        o_err    = sel ? ifb.error_o          : ifa.error_o;

  always @(posedge clk) if (rstn && o_yumi) yumi_cnt <= yumi_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with random host backpressure; words and response from the model.
  task automatic run_txn(input logic w, input logic [63:0] a, input logic [2:0] sz,
                         input logic [63:0] d, input logic [31:0] h0, input logic [31:0] h1,
                         output logic [63:0] got);
    logic [31:0] exp_q[$];
    logic [31:0] host_q[$];
    logic [7:0]  pb [8];
    logic [63:0] rv, ev;
    logic [2:0]  se3;
    int          se, nb, nw, off, budget, yc0;
    bit          done, yum, rr;
    se  = (sz > 3) ? 3 : int'(sz);
    se3 = 3'(se);
    nb  = 1 << se;
    nw  = (nb * 8 <= 32) ? 1 : (nb * 8) / 32;
    exp_q.push_back({w, se3, 28'h0});
    exp_q.push_back(a[31:0]);
    exp_q.push_back(a[63:32]);
    if (w) begin
      off = int'(a[2:0]);
      for (int k = 0; k < 8; k++) begin
        pb[k] = 8'h00;
        if (k < nb && off + k < 8) pb[k] = d[8*(off+k) +: 8];
      end
      for (int j = 0; j < nw; j++) exp_q.push_back({pb[4*j+3], pb[4*j+2], pb[4*j+1], pb[4*j]});
      ev = '0;
      if (sel) host_q.push_back(h0);
    end else begin
      host_q.push_back(h0);
      if (nw == 2) host_q.push_back(h1);
      rv = (nw == 2) ? {h1, h0} : {32'h0, h0};
      for (int k = 0; k < 8; k++) ev[8*k +: 8] = rv[8*(k % nb) +: 8];
    end
    got = 'x;
    yc0 = yumi_cnt;
    req_v = 1'b1; req_w = w; req_addr = a; req_size = sz; req_data = d;
    done = 0; budget = 0;
    while (!(done && exp_q.size() == 0 && host_q.size() == 0) && budget < 400) begin
      @(negedge clk);
      budget++;
      if (yumi_cnt != yc0) begin
        req_v = 1'b0; req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom};
        req_size = 3'($urandom_range(0, 7)); req_w = 1'($urandom);
      end
      yum = 0;
      if (o_mv) begin
        yum = ($urandom_range(0, 3) != 0);
        if (yum) begin
          chk("rq_pending", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) chk("rq_word", 64'(o_mdata), 64'(exp_q.pop_front()));
        end
      end
      m_yumi = yum;
      if (host_q.size() != 0 && o_mrdy && $urandom_range(0, 1) == 1) begin
        m_vi = 1'b1; m_di = host_q.pop_front();
      end else begin
        m_vi = 1'b0; m_di = $urandom;
      end
      if (o_rv && !done) begin
        chk("resp_w", 64'(o_rw), 64'(w));
        chk("resp_data", o_rdata, ev);
        got = o_rdata;
        rr = ($urandom_range(0, 2) != 0);
        resp_rdy = rr; done = rr;
      end else resp_rdy = 1'b0;
    end
    chk("txn_in_budget", 64'(budget < 400), 64'd1);
    @(negedge clk);
    resp_rdy = 1'b0; m_yumi = 1'b0; m_vi = 1'b0; req_v = 1'b0;
    chk("yumi_pulses", 64'(yumi_cnt - yc0), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_yumi"}, 64'(o_yumi), 64'd0);
    chk({tag, "_resp_v"}, 64'(o_rv), 64'd0);
    chk({tag, "_mmio_v"}, 64'(o_mv), 64'd0);
    chk({tag, "_count"}, 64'(o_mcount), 64'd0);
    chk({tag, "_error"}, 64'(o_err), 64'd0);
    chk({tag, "_ready"}, 64'(o_mrdy), 64'd0);
  endtask

  initial begin
    logic [31:0] t1w [4];
    logic [31:0] t4w [4];
    logic [63:0] got;
    int          yc0;
    t1w[0] = 32'hA000_0000; t1w[1] = 32'h2000_0004; t1w[2] = 32'h0; t1w[3] = 32'hDEAD_BEEF;
    t4w[0] = 32'h10; t4w[1] = 32'h0; t4w[2] = 32'h5566_7788; t4w[3] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(o_mrdy), 64'd1);

    // Posted write, no backpressure: response three cycles after the header.
    yc0 = yumi_cnt;
    req_v = 1'b1; req_w = 1'b1; req_addr = 64'h2000_0004; req_size = 3'd2;
    req_data = 64'hDEAD_BEEF_1234_5678;
    repeat (3) @(negedge clk);
    chk("t1_resp_early", 64'(o_rv), 64'd0);
    @(negedge clk);
    req_v = 1'b0;
    chk("t1_resp_v", 64'(o_rv), 64'd1);
    chk("t1_count", 64'(o_mcount), 64'd4);
    chk("t1_yumi", 64'(yumi_cnt - yc0), 64'd1);
    chk("t1_resp_w", 64'(o_rw), 64'd1);
    chk("t1_resp_data", o_rdata, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_word", 64'(o_mdata), 64'(t1w[i]));
      m_yumi = 1'b1;
      @(negedge clk);
    end
    m_yumi = 1'b0;
    chk("t1_drained", 64'(o_mcount), 64'd0);
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("t1_resp_done", 64'(o_rv), 64'd0);

    // Reads through the generic transaction path.
    run_txn(1'b0, 64'h1000, 3'd3, 64'h0, 32'h89AB_CDEF, 32'h0123_4567, got);
    chk("t2_read64", got, 64'h0123_4567_89AB_CDEF);
    run_txn(1'b0, 64'h1003, 3'd0, 64'h0, 32'h0000_00A5, 32'h0, got);
    chk("t3_read8", got, 64'hA5A5_A5A5_A5A5_A5A5);

    // Full request FIFO: the fifth word waits for a host dequeue.
    yc0 = yumi_cnt;
    req_v = 1'b1; req_w = 1'b1; req_addr = 64'h10; req_size = 3'd3;
    req_data = 64'h1122_3344_5566_7788;
    repeat (6) @(negedge clk);
    chk("t4_count_full", 64'(o_mcount), 64'd4);
    chk("t4_no_yumi", 64'(yumi_cnt - yc0), 64'd0);
    chk("t4_resp_v", 64'(o_rv), 64'd0);
    chk("t4_head", 64'(o_mdata), 64'hB000_0000);
    m_yumi = 1'b1;
    #1;
    chk("t4_yumi_comb", 64'(o_yumi), 64'd1);
    @(negedge clk);
    m_yumi = 1'b0; req_v = 1'b0;
    chk("t4_count_hold", 64'(o_mcount), 64'd4);
    chk("t4_resp_v_after", 64'(o_rv), 64'd1);
    chk("t4_yumi_once", 64'(yumi_cnt - yc0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_word", 64'(o_mdata), 64'(t4w[i]));
      m_yumi = 1'b1;
      @(negedge clk);
    end
    m_yumi = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;

    // Acknowledged write: response waits for the host word.
    sel = 1'b1;
    yc0 = yumi_cnt;
    req_v = 1'b1; req_w = 1'b1; req_addr = 64'h8; req_size = 3'd2; req_data = {$urandom, $urandom};
    m_yumi = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_resp", 64'(o_rv), 64'd0);
    chk("t5_count", 64'(o_mcount), 64'd0);
    chk("t5_yumi", 64'(yumi_cnt - yc0), 64'd1);
    req_v = 1'b0; m_yumi = 1'b0;
    m_vi = 1'b1; m_di = 32'h1;
    @(negedge clk);
    m_vi = 1'b0;
    chk("t5_resp_wait", 64'(o_rv), 64'd0);
    @(negedge clk);
    chk("t5_resp_v", 64'(o_rv), 64'd1);
    chk("t5_resp_w", 64'(o_rw), 64'd1);
    chk("t5_resp_data", o_rdata, 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_resp_hold", 64'(o_rv), 64'd1);
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("t5_resp_done", 64'(o_rv), 64'd0);
    sel = 1'b0;

    // Illegal size is clamped and flagged until reset.
    run_txn(1'b1, {$urandom, $urandom}, 3'd4, {$urandom, $urandom}, 32'h0, 32'h0, got);
    chk("t6_error_set", 64'(o_err), 64'd1);
    run_txn(1'b0, {$urandom, $urandom}, 3'd1, 64'h0, $urandom, $urandom, got);
    chk("t6_error_sticky", 64'(o_err), 64'd1);

    // Reset in the middle of a read with one host word already consumed.
    req_v = 1'b1; req_w = 1'b0; req_addr = 64'h40; req_size = 3'd3; m_yumi = 1'b1;
    repeat (4) @(negedge clk);
    m_vi = 1'b1; m_di = 32'h1234;
    @(negedge clk);
    m_vi = 1'b0;
    @(negedge clk);
    rstn = 1'b0; req_v = 1'b0; m_yumi = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("t6_midreset");
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_ready_back", 64'(o_mrdy), 64'd1);
    run_txn(1'b0, 64'h40, 3'd3, 64'h0, 32'hCAFE_F00D, 32'h0BAD_BEEF, got);
    chk("t6_read_after_reset", got, 64'h0BAD_BEEF_CAFE_F00D);

    // Random traffic on both engines.
    for (int n = 0; n < 30; n++)
      run_txn(1'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 3)),
              {$urandom, $urandom}, $urandom, $urandom, got);
    sel = 1'b1;
    for (int n = 0; n < 15; n++)
      run_txn(1'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 3)),
              {$urandom, $urandom}, $urandom, $urandom, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
